// File: rtl/common.sv
// Shared dbus request/response formats plus the memory-bus arbiter's owner and state types.
package common;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    ARB_PTW = 2'd0,
    ARB_D   = 2'd1,
    ARB_I   = 2'd2
  } arb_owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Fixed-priority pick among the three dbus sources; a starving fetch jumps to the front.
module arb_prio_sel
  import common::*;
(
  input  logic       ptw_valid,
  input  logic       d_valid,
  input  logic       i_valid,
  input  logic       starve,
  output logic [2:0] grant,
  output arb_owner_t owner
);

  // grant bit order: [0] PTW, [1] D, [2] I; all-zero when nothing is requesting
  always_comb begin
    grant = 3'b000;
    owner = ARB_PTW;
    if (starve && i_valid) begin
      grant = 3'b100;
      owner = ARB_I;
    end else if (ptw_valid) begin
      grant = 3'b001;
      owner = ARB_PTW;
    end else if (d_valid) begin
      grant = 3'b010;
      owner = ARB_D;
    end else if (i_valid) begin
      grant = 3'b100;
      owner = ARB_I;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges PTW, data and fetch dbus streams onto one memory port, one latched transaction at a time.
// Handshake: a source is granted while its valid is high in IDLE; the latched request is then
// driven with valid=1 until o_resp.data_ok, which is forwarded to the owner in the same cycle.
module mem_bus_arbiter
  import common::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        ptw_req,
  output dbus_resp_t       ptw_resp,
  input  dbus_req_t        d_req,
  output dbus_resp_t       d_resp,
  input  dbus_req_t        i_req,
  output dbus_resp_t       i_resp,
  output dbus_req_t        o_req,
  input  dbus_resp_t       o_resp,
  output arb_state_t       dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  arb_state_t       state;
  arb_owner_t       owner;
  dbus_req_t        lat_req;
  logic [CNT_W-1:0] starve_cnt;

  logic [2:0] grant;
  arb_owner_t sel_owner;
  dbus_req_t  sel_req;
  logic       starve;
  logic       i_loses;
  logic       drive_bus;

  assign starve  = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign i_loses = i_req.valid && !grant[2];

  arb_prio_sel u_prio_sel (
    .ptw_valid (ptw_req.valid),
    .d_valid   (d_req.valid),
    .i_valid   (i_req.valid),
    .starve    (starve),
    .grant     (grant),
    .owner     (sel_owner)
  );

  assign sel_req = ({$bits(dbus_req_t){grant[0]}} & ptw_req)
                 | ({$bits(dbus_req_t){grant[1]}} & d_req)
                 | ({$bits(dbus_req_t){grant[2]}} & i_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= ARB_PTW;
      lat_req    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|grant) begin
            lat_req <= sel_req;
            owner   <= sel_owner;
            state   <= ARB_BUSY;
            if (i_loses) begin
              if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ARB_BUSY: begin
          if (o_resp.data_ok) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Reset gates the bus and responses in the very cycle it is asserted, not one cycle later.
  assign drive_bus = (state == ARB_BUSY) && !reset;

  always_comb begin
    o_req    = '0;
    ptw_resp = '0;
    d_resp   = '0;
    i_resp   = '0;
    if (drive_bus) begin
      o_req       = lat_req;
      o_req.valid = 1'b1;
      case (owner)
        ARB_PTW: ptw_resp = o_resp;
        ARB_D:   d_resp   = o_resp;
        ARB_I:   i_resp   = o_resp;
        default: ;
      endcase
    end
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level arbitration model.
module tb_mem_bus_arbiter;
  import common::*;

  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = 4;
  localparam int W            = $bits(dbus_req_t);
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  dbus_req_t        ptw_req, d_req, i_req, o_req;
  dbus_resp_t       ptw_resp, d_resp, i_resp, o_resp;
  arb_state_t       dbg_state;
  logic [CNT_W-1:0] dbg_starve_cnt;

  int total = 0;
  int bad   = 0;

  // upstream model: pend[s] is the source's valid, rq[s] its current request
  logic      pend[3];
  dbus_req_t rq[3];
  int        model_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ptw_req        (ptw_req),
    .ptw_resp       (ptw_resp),
    .d_req          (d_req),
    .d_resp         (d_resp),
    .i_req          (i_req),
    .i_resp         (i_resp),
    .o_req          (o_req),
    .o_resp         (o_resp),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] x1(input logic v);
    return {127'b0, v};
  endfunction

  function automatic logic [127:0] xr(input dbus_resp_t r);
    return {62'b0, r};
  endfunction

  function automatic logic [127:0] xq(input dbus_req_t r);
    return {20'b0, r};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cyc();
    @(negedge clk);
  endtask

  task automatic drive_ports();
    ptw_req = pend[0] ? rq[0] : '0;
    d_req   = pend[1] ? rq[1] : '0;
    i_req   = pend[2] ? rq[2] : '0;
  endtask

  function automatic dbus_req_t mk_req(input int s);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = $urandom;
    r.size   = 3'($urandom_range(0, 3));
    r.strobe = (s == 2) ? 8'h00 : 8'($urandom);
    r.data   = (s == 2) ? 64'h0 : {$urandom, $urandom};
    return r;
  endfunction

  // Arbitration rule: fetch first once it has lost STARVE_LIMIT times in a row, else PTW > D > I.
  function automatic int model_pick();
    if (model_cnt >= STARVE_LIMIT && pend[2]) return 2;
    if (pend[0]) return 0;
    if (pend[1]) return 1;
    return 2;
  endfunction

  task automatic raise_random(input int excl, input int pct);
    for (int s = 0; s < 3; s++) begin
      if (!pend[s] && s != excl && $urandom_range(0, 99) < pct) begin
        pend[s] = 1'b1;
        rq[s]   = mk_req(s);
      end
    end
    drive_ports();
  endtask

  task automatic chk_resps(input int w, input dbus_resp_t bus);
    dbus_resp_t e[3];
    for (int s = 0; s < 3; s++) e[s] = (s == w) ? bus : '0;
    chk("ptw_resp", xr(ptw_resp), xr(e[0]));
    chk("d_resp",   xr(d_resp),   xr(e[1]));
    chk("i_resp",   xr(i_resp),   xr(e[2]));
  endtask

  task automatic chk_busy(input int w, input dbus_resp_t bus);
    chk("busy_state", x1(dbg_state), x1(ARB_BUSY));
    chk("o_req", xq(o_req), {20'b0, exp_q[0]});
    chk("starve_cnt", {124'b0, dbg_starve_cnt}, {124'b0, 4'(model_cnt)});
    chk_resps(w, bus);
  endtask

  // Called at the start of an IDLE cycle with at least one source pending.
  task automatic run_txn(input int lat, input logic [63:0] rdata, input bit withdraw, input int pct);
    int         w;
    dbus_req_t  exp_req;
    dbus_resp_t bus;
    w = model_pick();
    exp_req = rq[w];
    exp_req.valid = 1'b1;
    exp_q.push_back(exp_req);
    if (pend[2] && w != 2) begin
      if (model_cnt < CNT_MAX) model_cnt++;
    end else begin
      model_cnt = 0;
    end
    mid_cyc();
    chk("idle_state", x1(dbg_state), x1(ARB_IDLE));
    chk("idle_valid", x1(o_req.valid), x1(1'b0));
    chk_resps(-1, '0);
    next_cyc();
    if (withdraw) begin
      pend[w] = 1'b0;
      drive_ports();
    end
    raise_random(w, pct);
    for (int k = 0; k < lat; k++) begin
      bus.addr_ok = 1'($urandom);
      bus.data_ok = 1'b0;
      bus.data    = {$urandom, $urandom};
      o_resp = bus;
      mid_cyc();
      chk_busy(w, bus);
      next_cyc();
      raise_random(w, pct);
    end
    bus.addr_ok = 1'($urandom);
    bus.data_ok = 1'b1;
    bus.data    = rdata;
    o_resp = bus;
    mid_cyc();
    chk_busy(w, bus);
    void'(exp_q.pop_front());
    next_cyc();
    o_resp  = '0;
    pend[w] = 1'b0;
    raise_random(-1, pct);
  endtask

  initial begin
    int        s;
    dbus_resp_t bus;
    reset  = 1'b1;
    o_resp = '0;
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0;
      rq[k]   = '0;
    end
    drive_ports();

    // reset state
    next_cyc();
    mid_cyc();
    chk("rst_state", x1(dbg_state), x1(ARB_IDLE));
    chk("rst_cnt", {124'b0, dbg_starve_cnt}, 128'd0);
    chk("rst_o_req", xq(o_req), 128'd0);
    chk_resps(-1, '0);
    next_cyc();
    reset = 1'b0;
    next_cyc();

    // single fetch: grant next cycle, data_ok two cycles after that
    pend[2] = 1'b1;
    rq[2]   = '{valid: 1'b1, addr: 32'h8000_0000, size: 3'd2, strobe: 8'h00, data: 64'h0};
    drive_ports();
    run_txn(2, 64'h0000_0000_0000_0013, 1'b0, 0);
    mid_cyc();
    chk("fetch_done_state", x1(dbg_state), x1(ARB_IDLE));
    chk("fetch_done_i_resp", xr(i_resp), 128'd0);
    next_cyc();

    // all three at once: PTW, D, I with one idle cycle between
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b1;
      rq[k]   = mk_req(k);
    end
    drive_ports();
    for (int k = 0; k < 3; k++) run_txn($urandom_range(0, 2), {$urandom, $urandom}, 1'b0, 0);

    // data request withdrawn after grant keeps the latched request on the bus
    pend[1] = 1'b1;
    rq[1]   = '{valid: 1'b1, addr: 32'h8000_1000, size: 3'd3, strobe: 8'hFF,
                data: 64'h0000_0000_DEAD_BEEF};
    drive_ports();
    run_txn(3, {$urandom, $urandom}, 1'b1, 0);

    // fetch starvation: D always pending, PTW joins for the ninth arbitration
    pend[1] = 1'b1; rq[1] = mk_req(1);
    pend[2] = 1'b1; rq[2] = mk_req(2);
    drive_ports();
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        pend[0] = 1'b1;
        rq[0]   = mk_req(0);
        drive_ports();
      end
      run_txn($urandom_range(0, 2), {$urandom, $urandom}, 1'b0, 0);
      if (k < 8 && !pend[1]) begin
        pend[1] = 1'b1;
        rq[1]   = mk_req(1);
        drive_ports();
      end
    end
    while (pend[0] || pend[1] || pend[2]) run_txn($urandom_range(0, 2), {$urandom, $urandom}, 1'b0, 0);

    // reset in the middle of a transaction, stray data_ok afterwards
    pend[1] = 1'b1; rq[1] = mk_req(1);
    drive_ports();
    mid_cyc();
    next_cyc();
    mid_cyc();
    chk("pre_rst_valid", x1(o_req.valid), x1(1'b1));
    next_cyc();
    reset   = 1'b1;
    pend[1] = 1'b0;
    drive_ports();
    mid_cyc();
    chk("mid_rst_valid", x1(o_req.valid), x1(1'b0));
    chk_resps(-1, '0);
    next_cyc();
    reset = 1'b0;
    model_cnt = 0;
    mid_cyc();
    chk("post_rst_state", x1(dbg_state), x1(ARB_IDLE));
    next_cyc();
    mid_cyc();
    next_cyc();
    bus.addr_ok = 1'b1;
    bus.data_ok = 1'b1;
    bus.data    = {$urandom, $urandom};
    o_resp = bus;
    mid_cyc();
    chk("stray_state", x1(dbg_state), x1(ARB_IDLE));
    chk("stray_valid", x1(o_req.valid), x1(1'b0));
    chk_resps(-1, '0);
    next_cyc();
    o_resp = '0;
    mid_cyc();
    chk("stray_after_state", x1(dbg_state), x1(ARB_IDLE));
    next_cyc();

    // randomized traffic, including requests raised while busy and withdrawals
    for (int n = 0; n < 150; n++) begin
      if (!(pend[0] || pend[1] || pend[2])) begin
        s = $urandom_range(0, 2);
        pend[s] = 1'b1;
        rq[s]   = mk_req(s);
        drive_ports();
      end
      run_txn($urandom_range(0, 3), {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the core. Merges three dbus-format request streams onto the single memory port: MMU page-table walk, data access and instruction fetch.
- Instruction fetch arrives already widened to dbus format, with the address translated by the MMU.
- Grants one owner at a time and holds the grant for a full transaction.
- Latches the granted request so the downstream request stays stable even if the upstream stage flushes.
- Prevents instruction-fetch starvation with a bounded wait counter.

Parameters:
- STARVE_LIMIT, 8: number of consecutive lost arbitrations after which the instruction port is promoted to highest priority.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ptw_req  in  dbus_req_t  page-table-walk request from the MMU
- ptw_resp  out  dbus_resp_t  response to the MMU
- d_req  in  dbus_req_t  data access from the memory stage
- d_resp  out  dbus_resp_t  response to the memory stage
- i_req  in  dbus_req_t  instruction fetch, physical address, strobe = 0
- i_resp  out  dbus_resp_t  response to fetch; fetch uses data[31:0]
- o_req  out  dbus_req_t  request to the memory bus
- o_resp  in  dbus_resp_t  response from the memory bus

Behaviour:
- State: IDLE, BUSY. Register owner ∈ {PTW, D, I}. Register lat_req holds the latched request. Register starve_cnt (CNT_W bits).
- Reset: state = IDLE, owner = PTW, lat_req = '0, starve_cnt = 0. In the same cycle o_req.valid = 0 and all three *_resp outputs are '0.
- IDLE:
  - o_req.valid = 0; all responses '0.
  - If any upstream valid is set, pick a winner, latch its whole request into lat_req, set owner, go to BUSY.
- Priority:
  - Normal order: PTW > D > I.
  - If starve_cnt >= STARVE_LIMIT and i_req.valid, order is I > PTW > D.
- Grant latency:
  - Winner sampled in cycle t; o_req.valid = 1 from cycle t+1.
  - Minimum latency from request to downstream valid is 1 cycle.
- BUSY:
  - o_req = lat_req with valid forced to 1.
  - o_resp is routed to owner's resp port. Non-owners see addr_ok = data_ok = 0 and data = 0.
  - addr_ok is passed through unchanged.
- Completion:
  - When o_resp.data_ok = 1 in BUSY: pass data_ok and data to the owner that cycle, go to IDLE next cycle.
  - This gives one bubble cycle between back-to-back grants.
- Upstream withdraw: if the owner's valid drops mid-transaction, lat_req is still driven until data_ok and data_ok is still delivered. Upstream ignores data_ok on a flushed request.
- Starvation counter:
  - Updated only on IDLE→BUSY transitions.
  - I loses while i_req.valid = 1: starve_cnt += 1, saturating at 2^CNT_W−1.
  - I wins, or i_req.valid = 0 at arbitration: starve_cnt = 0.
- Simultaneous events:
  - Requests arriving while BUSY are ignored and no response is given to them; they wait until IDLE.
  - A request arriving in the same cycle as data_ok is arbitrated at the following IDLE cycle.
- Reset mid-transaction: abandon immediately to IDLE. Any later stray data_ok from the bus while IDLE is dropped: no response asserted.

Decomposition:
- Package `common`, already holding dbus_req_t / dbus_resp_t, gains:
  - typedef arb_owner_t (enum u2: ARB_PTW, ARB_D, ARB_I)
  - typedef arb_state_t (enum: ARB_IDLE, ARB_BUSY)
- One sub-module: arb_prio_sel. Purely combinational. Inputs: three valids and the starve flag. Outputs: a grant one-hot and owner.
- The top holds the FSM, latch, counter and response routing.

Test Plan:
- Single I fetch, addr 0x8000_0000, bus data_ok after 3 cycles, data 0x0000_0013 -> o_req.valid rises 1 cycle after i_req.valid; i_resp.data_ok pulses 1 cycle with data[31:0] = 0x13; state back to IDLE the next cycle.
- PTW, D and I valid in the same cycle -> grant order PTW, then D, then I; each o_req.addr matches its source; each gap between transactions is exactly 1 IDLE cycle.
- D held valid continuously while I is waiting, STARVE_LIMIT = 8 -> after 8 D grants, the 9th grant goes to I even though D and PTW are valid; starve_cnt returns to 0.
- D granted with addr 0x8000_1000, strobe 0xFF, data 0xDEAD_BEEF; d_req.valid dropped one cycle later -> o_req keeps the latched addr, strobe and data until data_ok; d_resp.data_ok is still pulsed.
- reset asserted in BUSY with no data_ok yet, then data_ok arrives 2 cycles after reset drops -> o_req.valid = 0 in the reset cycle; no *_resp.data_ok asserted at any point.
- Non-owner isolation: I in BUSY, bus returns addr_ok and data_ok -> ptw_resp and d_resp remain all-zero throughout.
